// File: rtl/i2c_sensor_slave_pkg.sv
// rtl/i2c_sensor_slave_pkg.sv - shared FSM states, register map and STATUS bit positions
package i2c_sensor_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_t;

  localparam logic [7:0] REG_FIFO_DATA  = 8'h00;
  localparam logic [7:0] REG_FIFO_COUNT = 8'h01;
  localparam logic [7:0] REG_THRESHOLD  = 8'h02;
  localparam logic [7:0] REG_STATUS     = 8'h03;
  localparam logic [7:0] REG_WHO_AM_I   = 8'h04;

  localparam int STAT_OVERFLOW_BIT = 7;
  localparam int STAT_EMPTY_BIT    = 6;
  localparam int STAT_FULL_BIT     = 5;

  // FIFO_DATA holds the pointer so a burst keeps draining the FIFO
  function automatic logic [7:0] next_reg_ptr(input logic [7:0] ptr);
    return (ptr == REG_FIFO_DATA) ? ptr : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_sensor_slave_sync_fifo.sv
// rtl/i2c_sensor_slave_sync_fifo.sv - show-ahead FIFO with wrap-bit binary pointers
module sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // a same-cycle pop frees the slot, so push is accepted even when full
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // pointer update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2c_sensor_slave.sv
// rtl/i2c_sensor_slave.sv - I2C target exposing a sample FIFO through a small register map
module i2c_sensor_slave
  import i2c_sensor_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h57,
  parameter int         FIFO_DEPTH = 32,
  parameter logic [7:0] WHO_AM_I   = 8'h15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       push_ready,
  output logic [8:0] fifo_count,
  output logic       interupt,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic       sda_oe_d;
  logic [3:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr;
  logic       rw_q, mack_q;
  logic [7:0] reg_ptr, threshold, reg_rdata, status;
  logic       overflow;
  logic       ld_tx, ld_ptr, wr_reg, addr_hit, addr_miss;

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [7:0]    fifo_head;
  logic [AW:0]   fifo_cnt;

  // two-flop synchroniser plus history flop; idle bus level is high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 && !scl_h;
  assign scl_fall  = !scl_s2 && scl_h;
  assign start_det = scl_s2 && scl_h && sda_h && !sda_s2;
  assign stop_det  = scl_s2 && scl_h && !sda_h && sda_s2;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign fifo_count = 9'(fifo_cnt);
  assign push_ready = !fifo_full;
  assign interupt   = (threshold != 8'd0) && (fifo_count >= {1'b0, threshold});
  assign fifo_pop   = ld_tx && (reg_ptr == REG_FIFO_DATA) && !fifo_empty;

  // register read mux and STATUS assembly
  always_comb begin
    status                    = 8'h00;
    status[STAT_OVERFLOW_BIT] = overflow;
    status[STAT_EMPTY_BIT]    = fifo_empty;
    status[STAT_FULL_BIT]     = fifo_full;
    case (reg_ptr)
      REG_FIFO_DATA:  reg_rdata = fifo_empty ? 8'h00 : fifo_head;
      REG_FIFO_COUNT: reg_rdata = (fifo_count > 9'd255) ? 8'hFF : fifo_count[7:0];
      REG_THRESHOLD:  reg_rdata = threshold;
      REG_STATUS:     reg_rdata = status;
      REG_WHO_AM_I:   reg_rdata = WHO_AM_I;
      default:        reg_rdata = 8'h00;
    endcase
  end

  // bus FSM next state; SDA only moves on the cycle after a synced SCL fall
  always_comb begin
    state_d   = state_q;
    sda_oe_d  = sda_oe;
    ld_tx     = 1'b0;
    ld_ptr    = 1'b0;
    wr_reg    = 1'b0;
    addr_hit  = 1'b0;
    addr_miss = 1'b0;
    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      sda_oe_d = 1'b0;
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: begin
          if (bit_cnt == 4'd8) begin
            if (rx_sr[7:1] == SLAVE_ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = 1'b1;
              addr_hit = 1'b1;
            end else begin
              state_d   = ST_IDLE;
              addr_miss = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (rw_q) begin
            state_d  = ST_RD_DATA;
            ld_tx    = 1'b1;
            sda_oe_d = ~reg_rdata[7];
          end else begin
            state_d  = ST_REG;
            sda_oe_d = 1'b0;
          end
        end
        ST_REG: begin
          if (bit_cnt == 4'd8) begin
            state_d  = ST_REG_ACK;
            sda_oe_d = 1'b1;
            ld_ptr   = 1'b1;
          end
        end
        ST_REG_ACK, ST_WR_ACK: begin
          state_d  = ST_WR_DATA;
          sda_oe_d = 1'b0;
        end
        ST_WR_DATA: begin
          if (bit_cnt == 4'd8) begin
            state_d  = ST_WR_ACK;
            sda_oe_d = 1'b1;
            wr_reg   = 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (bit_cnt == 4'd8) begin
            state_d  = ST_RD_ACK;
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = ~tx_sr[6];
          end
        end
        ST_RD_ACK: begin
          if (!mack_q) begin
            state_d  = ST_RD_DATA;
            ld_tx    = 1'b1;
            sda_oe_d = ~reg_rdata[7];
          end else begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state and SDA driver registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sda_oe  <= 1'b0;
    end else begin
      state_q <= state_d;
      sda_oe  <= sda_oe_d;
    end
  end

  // bit counter, shifters and sampled control bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= 4'd0;
      rx_sr   <= 8'h00;
      tx_sr   <= 8'h00;
      rw_q    <= 1'b0;
      mack_q  <= 1'b1;
    end else begin
      if (start_det || (state_d != state_q))
        bit_cnt <= 4'd0;
      else if (scl_rise && (state_q inside {ST_ADDR, ST_REG, ST_WR_DATA, ST_RD_DATA}))
        bit_cnt <= bit_cnt + 4'd1;
      if (scl_rise && (state_q inside {ST_ADDR, ST_REG, ST_WR_DATA}))
        rx_sr <= {rx_sr[6:0], sda_s2};
      if (scl_rise && (state_q == ST_RD_ACK))
        mack_q <= sda_s2;
      if (addr_hit)
        rw_q <= rx_sr[0];
      if (ld_tx)
        tx_sr <= reg_rdata;
      else if (scl_fall && (state_q == ST_RD_DATA) && (bit_cnt != 4'd8))
        tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  // register file, pointer, overflow flag and busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_ptr   <= 8'h00;
      threshold <= 8'h00;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (ld_ptr)
        reg_ptr <= rx_sr;
      else if (ld_tx || wr_reg)
        reg_ptr <= next_reg_ptr(reg_ptr);
      if (wr_reg && (reg_ptr == REG_THRESHOLD))
        threshold <= rx_sr;
      // a drop in the same cycle as the STATUS read keeps the flag set
      if (push_valid && fifo_full && !fifo_pop)
        overflow <= 1'b1;
      else if (ld_tx && (reg_ptr == REG_STATUS))
        overflow <= 1'b0;
      if (stop_det || addr_miss)
        busy <= 1'b0;
      else if (addr_hit)
        busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_sensor_slave.sv
// tb/tb_i2c_sensor_slave.sv - directed bench driving the slave with a bit-banged I2C master
`timescale 1ns/1ps
module tb_i2c_sensor_slave;
  import i2c_sensor_slave_pkg::*;

  localparam time Q = 50ns;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl, m_sda;
  logic       sda_line;
  logic       sda_oe;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;
  logic [8:0] fifo_count;
  logic       interupt;
  logic       busy;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] rd_buf [64];
  logic       ack_err;
  logic       mon_en, oe_seen, busy_seen;

  always #5 clk = ~clk;

  assign sda_line = m_sda & ~sda_oe;

  i2c_sensor_slave dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (m_scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .fifo_count (fifo_count),
    .interupt   (interupt),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (!mon_en) begin
      oe_seen   <= 1'b0;
      busy_seen <= 1'b0;
    end else begin
      if (sda_oe) oe_seen   <= 1'b1;
      if (busy)   busy_seen <= 1'b1;
    end
  end

  initial begin
    #(2ms);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
    #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q;
    m_scl = 1'b1; #Q; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    ack = sda_line; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      d = {d[6:0], sda_line}; #Q;
      m_scl = 1'b0; #Q;
    end
    m_sda = nack; #Q;
    m_scl = 1'b1; #Q; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic read_seq(input logic [7:0] ptr, input int n);
    logic       a;
    logic [7:0] d;
    ack_err = 1'b0;
    i2c_start();
    write_byte(8'hAE, a); ack_err |= a;
    write_byte(ptr, a);   ack_err |= a;
    i2c_start();
    write_byte(8'hAF, a); ack_err |= a;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      rd_buf[i] = d;
    end
    i2c_stop();
  endtask

  task automatic write_reg(input logic [7:0] ptr, input logic [7:0] data);
    logic a;
    ack_err = 1'b0;
    i2c_start();
    write_byte(8'hAE, a); ack_err |= a;
    write_byte(ptr, a);   ack_err |= a;
    write_byte(data, a);  ack_err |= a;
    i2c_stop();
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    push_valid = 1'b1;
    push_data  = d;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_checks++; if (push_ready !== 1'b1) $display("FAIL reset_push_ready: got %b want 1", push_ready); else n_pass++;
    n_checks++; if (fifo_count !== 9'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
    n_checks++; if (interupt !== 1'b0) $display("FAIL reset_interupt: got %b want 0", interupt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_burst_read();
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    read_seq(8'h00, 3);
    n_checks++; if (ack_err !== 1'b0) $display("FAIL burst_acks: got NACK want ACK"); else n_pass++;
    n_checks++; if (rd_buf[0] !== 8'hA1) $display("FAIL burst_b0: got %h want a1", rd_buf[0]); else n_pass++;
    n_checks++; if (rd_buf[1] !== 8'hB2) $display("FAIL burst_b1: got %h want b2", rd_buf[1]); else n_pass++;
    n_checks++; if (rd_buf[2] !== 8'hC3) $display("FAIL burst_b2: got %h want c3", rd_buf[2]); else n_pass++;
    n_checks++; if (fifo_count !== 9'd0) $display("FAIL burst_count: got %0d want 0", fifo_count); else n_pass++;
  endtask

  task automatic test_wrong_addr();
    logic a, a2;
    mon_en = 1'b1;
    i2c_start();
    write_byte(8'h44, a);
    write_byte(8'h00, a2);
    i2c_stop();
    #(4*Q);
    n_checks++; if (a !== 1'b1) $display("FAIL wrong_addr_ack: got %b want 1", a); else n_pass++;
    n_checks++; if (oe_seen !== 1'b0) $display("FAIL wrong_addr_sda_oe: got %b want 0", oe_seen); else n_pass++;
    n_checks++; if (busy_seen !== 1'b0) $display("FAIL wrong_addr_busy: got %b want 0", busy_seen); else n_pass++;
    mon_en = 1'b0;
  endtask

  task automatic test_empty_and_id();
    read_seq(8'h00, 2);
    n_checks++; if (rd_buf[0] !== 8'h00) $display("FAIL empty_b0: got %h want 00", rd_buf[0]); else n_pass++;
    n_checks++; if (rd_buf[1] !== 8'h00) $display("FAIL empty_b1: got %h want 00", rd_buf[1]); else n_pass++;
    n_checks++; if (fifo_count !== 9'd0) $display("FAIL empty_count: got %0d want 0", fifo_count); else n_pass++;
    read_seq(8'h04, 2);
    n_checks++; if (rd_buf[0] !== 8'h15) $display("FAIL who_am_i: got %h want 15", rd_buf[0]); else n_pass++;
    n_checks++; if (rd_buf[1] !== 8'h00) $display("FAIL reg_05: got %h want 00", rd_buf[1]); else n_pass++;
  endtask

  task automatic test_threshold();
    write_reg(8'h02, 8'h04);
    n_checks++; if (interupt !== 1'b0) $display("FAIL thr_irq_empty: got %b want 0", interupt); else n_pass++;
    push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
    n_checks++; if (interupt !== 1'b0) $display("FAIL thr_irq_3: got %b want 0", interupt); else n_pass++;
    push_byte(8'h34);
    n_checks++; if (interupt !== 1'b1) $display("FAIL thr_irq_4: got %b want 1", interupt); else n_pass++;
    read_seq(8'h02, 1);
    n_checks++; if (rd_buf[0] !== 8'h04) $display("FAIL thr_readback: got %h want 04", rd_buf[0]); else n_pass++;
    read_seq(8'h00, 1);
    n_checks++; if (rd_buf[0] !== 8'h31) $display("FAIL thr_pop: got %h want 31", rd_buf[0]); else n_pass++;
    n_checks++; if (interupt !== 1'b0) $display("FAIL thr_irq_after_pop: got %b want 0", interupt); else n_pass++;
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 29; i++) push_byte(8'h80 + 8'(i));
    push_byte(8'h55);
    n_checks++; if (push_ready !== 1'b0) $display("FAIL full_push_ready: got %b want 0", push_ready); else n_pass++;
    n_checks++; if (fifo_count !== 9'd32) $display("FAIL full_count: got %0d want 32", fifo_count); else n_pass++;
    read_seq(8'h03, 1);
    n_checks++; if (rd_buf[0] !== 8'hA0) $display("FAIL status_1: got %h want a0", rd_buf[0]); else n_pass++;
    read_seq(8'h03, 1);
    n_checks++; if (rd_buf[0] !== 8'h20) $display("FAIL status_2: got %h want 20", rd_buf[0]); else n_pass++;
    read_seq(8'h01, 1);
    n_checks++; if (rd_buf[0] !== 8'h20) $display("FAIL count_reg: got %h want 20", rd_buf[0]); else n_pass++;
    read_seq(8'h00, 32);
    n_checks++; if (rd_buf[0] !== 8'h32) $display("FAIL drain_first: got %h want 32", rd_buf[0]); else n_pass++;
    n_checks++; if (rd_buf[31] !== 8'h9C) $display("FAIL drain_last: got %h want 9c", rd_buf[31]); else n_pass++;
    n_checks++; if (fifo_count !== 9'd0) $display("FAIL drain_count: got %0d want 0", fifo_count); else n_pass++;
  endtask

  task automatic test_abort();
    logic a;
    i2c_start();
    write_byte(8'hAE, a);
    n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_set: got %b want 1", busy); else n_pass++;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    #(2*Q);
    n_checks++; if (dut.state_q !== ST_IDLE) $display("FAIL stop_mid_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL stop_mid_busy: got %b want 0", busy); else n_pass++;
    i2c_start();
    write_byte(8'hAE, a);
    write_byte(8'h04, a);
    i2c_start();
    write_byte(8'hAF, a);
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL rst_mid_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_checks++; if (dut.state_q !== ST_IDLE) $display("FAIL rst_mid_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    push_byte(8'h3C);
    n_checks++; if (interupt !== 1'b0) $display("FAIL rst_thr_cleared: got %b want 0", interupt); else n_pass++;
    read_seq(8'h00, 1);
    n_checks++; if (rd_buf[0] !== 8'h3C) $display("FAIL post_rst_read: got %h want 3c", rd_buf[0]); else n_pass++;
    n_checks++; if (fifo_count !== 9'd0) $display("FAIL post_rst_count: got %0d want 0", fifo_count); else n_pass++;
  endtask

  initial begin
    reset      = 1'b0;
    m_scl      = 1'b1;
    m_sda      = 1'b1;
    push_valid = 1'b0;
    push_data  = 8'h00;
    mon_en     = 1'b0;
    ack_err    = 1'b0;
    test_reset();
    test_burst_read();
    test_wrong_addr();
    test_empty_and_id();
    test_threshold();
    test_full_overflow();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
